// File: rtl/j1_dmem_arbiter.sv
// Shares the single-port J1 data RAM between the core dbus and a Wishbone B4 classic slave.
// The core always wins the port. Wishbone accesses use cycles the core leaves idle.
module j1_dmem_arbiter #(
    parameter int unsigned AW = 13
) (
    input  logic          clk,
    input  logic          reset,
    // core data bus
    input  logic [15:0]   d_adr,
    input  logic          d_re,
    input  logic          d_we,
    input  logic [15:0]   d_dat_i,
    output logic [15:0]   d_dat_o,
    // wishbone slave
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [1:0]    wb_sel_i,
    input  logic [15:0]   wb_adr_i,
    input  logic [15:0]   wb_dat_i,
    output logic [15:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    // data RAM port
    output logic          ram_en,
    output logic          ram_we,
    output logic [1:0]    ram_be,
    output logic [AW-1:0] ram_adr,
    output logic [15:0]   ram_d,
    input  logic [15:0]   ram_q
);

    typedef enum logic [1:0] {StIdle, StResp, StAck, StErr} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [15:0] wb_dat_q, wb_dat_d;

    logic        core_req;
    logic        wb_req;
    logic        wb_in_range;
    logic        wb_issue;
    logic [15:0] wb_adr_hi;
    logic        unused_adr_bits;

    assign core_req        = d_re | d_we;
    assign wb_req          = wb_cyc_i & wb_stb_i;
    assign wb_adr_hi       = wb_adr_i >> AW;
    assign wb_in_range     = (wb_adr_hi == 16'h0000);
    assign wb_issue        = (state_q == StIdle) & wb_req & wb_in_range & ~core_req;
    assign unused_adr_bits = ^d_adr[15:AW];

    assign d_dat_o  = ram_q;
    assign wb_dat_o = wb_dat_q;
    // Gated by cyc so a master that abandons the cycle never sees a stray ack/err.
    assign wb_ack_o = (state_q == StAck) & wb_cyc_i;
    assign wb_err_o = (state_q == StErr) & wb_cyc_i;

    always_comb begin
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        ram_be  = 2'b00;
        ram_adr = '0;
        ram_d   = 16'h0000;
        if (core_req) begin
            ram_en  = 1'b1;
            ram_we  = d_we;
            ram_be  = 2'b11;
            ram_adr = d_adr[AW-1:0];
            ram_d   = d_dat_i;
        end else if (wb_issue) begin
            ram_en  = 1'b1;
            ram_we  = wb_we_i;
            ram_be  = wb_we_i ? wb_sel_i : 2'b11;
            ram_adr = wb_adr_i[AW-1:0];
            ram_d   = wb_dat_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        wb_dat_d = wb_dat_q;
        unique case (state_q)
            StIdle: begin
                if (wb_req && !wb_in_range) begin
                    state_d = StErr;
                end else if (wb_issue) begin
                    state_d = StResp;
                    we_d    = wb_we_i;
                end
            end
            StResp: begin
                if (wb_cyc_i) begin
                    state_d = StAck;
                    if (!we_q) begin
                        wb_dat_d = ram_q;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StAck:   state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            wb_dat_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            wb_dat_q <= wb_dat_d;
        end
    end

endmodule

// File: tb/tb_j1_dmem_arbiter.sv
// Directed bench for j1_dmem_arbiter with a byte-enabled synchronous RAM model.
module tb_j1_dmem_arbiter;

    localparam int unsigned AW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   d_adr, d_dat_i, d_dat_o;
    logic          d_re, d_we;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [1:0]    wb_sel_i;
    logic [15:0]   wb_adr_i, wb_dat_i, wb_dat_o;
    logic          wb_ack_o, wb_err_o;
    logic          ram_en, ram_we;
    logic [1:0]    ram_be;
    logic [AW-1:0] ram_adr;
    logic [15:0]   ram_d;
    logic [15:0]   ram_q;

    logic [15:0] mem [0:(1<<AW)-1];

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                if (ram_be[1]) mem[ram_adr][15:8] <= ram_d[15:8];
                if (ram_be[0]) mem[ram_adr][7:0]  <= ram_d[7:0];
            end
            ram_q <= mem[ram_adr];
        end
    end

    j1_dmem_arbiter #(.AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .d_adr    (d_adr),
        .d_re     (d_re),
        .d_we     (d_we),
        .d_dat_i  (d_dat_i),
        .d_dat_o  (d_dat_o),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_sel_i (wb_sel_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_be   (ram_be),
        .ram_adr  (ram_adr),
        .ram_d    (ram_d),
        .ram_q    (ram_q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic core_write(input logic [15:0] adr, input logic [15:0] dat);
        d_we = 1'b1; d_adr = adr; d_dat_i = dat;
        tick();
        d_we = 1'b0;
    endtask

    task automatic wb_start(input logic we, input logic [1:0] sel, input logic [15:0] adr,
                            input logic [15:0] dat);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_sel_i = sel; wb_adr_i = adr; wb_dat_i = dat;
        #1;
    endtask

    task automatic wb_stop();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        d_adr = '0; d_re = 1'b0; d_we = 1'b0; d_dat_i = '0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_sel_i = '0; wb_adr_i = '0; wb_dat_i = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ack", 32'(wb_ack_o), 32'h0);
        chk("rst_err", 32'(wb_err_o), 32'h0);
        chk("rst_dat", 32'(wb_dat_o), 32'h0);
        chk("rst_en",  32'(ram_en),   32'h0);
        tick();

        core_write(16'h0010, 16'hBEEF);
        core_write(16'h0040, 16'hAAAA);
        core_write(16'h0050, 16'h5A5A);
        tick();

        // 1: core read, one-cycle latency; upper address bits ignored
        d_re = 1'b1; d_adr = 16'hE010;
        #1;
        chk("c_rd_en",  32'(ram_en),  32'h1);
        chk("c_rd_we",  32'(ram_we),  32'h0);
        chk("c_rd_adr", 32'(ram_adr), 32'h0010);
        tick();
        d_re = 1'b0;
        chk("c_rd_dat", 32'(d_dat_o), 32'hBEEF);

        // 2: WB write then read with idle core
        wb_start(1'b1, 2'b11, 16'h0020, 16'h1234);
        chk("w_en",  32'(ram_en),  32'h1);
        chk("w_we",  32'(ram_we),  32'h1);
        chk("w_adr", 32'(ram_adr), 32'h0020);
        chk("w_d",   32'(ram_d),   32'h1234);
        tick();
        chk("w_ack_n1", 32'(wb_ack_o), 32'h0);
        chk("w_en_n1",  32'(ram_en),   32'h0);
        tick();
        chk("w_ack_n2", 32'(wb_ack_o), 32'h1);
        wb_stop();
        chk("w_ack_nocyc", 32'(wb_ack_o), 32'h0);
        tick();
        chk("w_mem", 32'(mem[16'h0020]), 32'h1234);
        wb_start(1'b0, 2'b11, 16'h0020, 16'h0000);
        tick();
        tick();
        chk("r_ack", 32'(wb_ack_o), 32'h1);
        chk("r_dat", 32'(wb_dat_o), 32'h1234);
        wb_stop();
        tick();
        chk("r_ack_done", 32'(wb_ack_o), 32'h0);

        // 3: conflict with core write, WB slips one cycle
        d_we = 1'b1; d_adr = 16'h0030; d_dat_i = 16'h7777;
        wb_start(1'b0, 2'b11, 16'h0050, 16'h0000);
        chk("cf_adr_n",  32'(ram_adr), 32'h0030);
        chk("cf_we_n",   32'(ram_we),  32'h1);
        chk("cf_d_n",    32'(ram_d),   32'h7777);
        tick();
        d_we = 1'b0;
        #1;
        chk("cf_adr_n1", 32'(ram_adr), 32'h0050);
        chk("cf_en_n1",  32'(ram_en),  32'h1);
        chk("cf_we_n1",  32'(ram_we),  32'h0);
        tick();
        chk("cf_ack_n2", 32'(wb_ack_o), 32'h0);
        tick();
        chk("cf_ack_n3", 32'(wb_ack_o), 32'h1);
        chk("cf_dat",    32'(wb_dat_o), 32'h5A5A);
        chk("cf_mem",    32'(mem[16'h0030]), 32'h7777);
        wb_stop();
        tick();

        // 4: byte-lane writes
        wb_start(1'b1, 2'b01, 16'h0040, 16'h5566);
        chk("b01_be", 32'(ram_be), 32'h1);
        tick();
        tick();
        chk("b01_ack", 32'(wb_ack_o), 32'h1);
        wb_stop();
        tick();
        chk("b01_mem", 32'(mem[16'h0040]), 32'hAA66);
        wb_start(1'b1, 2'b00, 16'h0040, 16'h1111);
        chk("b00_en", 32'(ram_en), 32'h1);
        chk("b00_be", 32'(ram_be), 32'h0);
        tick();
        tick();
        chk("b00_ack", 32'(wb_ack_o), 32'h1);
        wb_stop();
        tick();
        chk("b00_mem", 32'(mem[16'h0040]), 32'hAA66);

        // 5: out-of-range address
        wb_start(1'b0, 2'b11, 16'h8000, 16'h0000);
        chk("oor_en", 32'(ram_en), 32'h0);
        tick();
        chk("oor_err", 32'(wb_err_o), 32'h1);
        chk("oor_ack", 32'(wb_ack_o), 32'h0);
        chk("oor_dat", 32'(wb_dat_o), 32'h5A5A);
        wb_stop();
        tick();
        chk("oor_err_done", 32'(wb_err_o), 32'h0);
        chk("oor_ack_done", 32'(wb_ack_o), 32'h0);

        // 6a: reset while in RESP
        wb_start(1'b0, 2'b11, 16'h0020, 16'h0000);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr_ack", 32'(wb_ack_o), 32'h0);
        chk("rr_dat", 32'(wb_dat_o), 32'h0);
        wb_stop();
        tick();
        chk("rr_ack2", 32'(wb_ack_o), 32'h0);

        // 6b: cyc dropped while in RESP
        wb_start(1'b0, 2'b11, 16'h0050, 16'h0000);
        tick();
        wb_stop();
        tick();
        chk("ab_ack1", 32'(wb_ack_o), 32'h0);
        tick();
        chk("ab_ack2", 32'(wb_ack_o), 32'h0);
        chk("ab_dat",  32'(wb_dat_o), 32'h0);
        wb_start(1'b0, 2'b11, 16'h0040, 16'h0000);
        tick();
        tick();
        chk("ab_rd_ack", 32'(wb_ack_o), 32'h1);
        chk("ab_rd_err", 32'(wb_err_o), 32'h0);
        chk("ab_rd_dat", 32'(wb_dat_o), 32'hAA66);
        wb_stop();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
